// File: rtl/game_pkg.sv
// Shared types and helpers for the modulus game sequencer.
// State encoding, field widths and the level-scaled drain period.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    GEN   = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam int LEVEL_W = 3;
  localparam int SCORE_W = 10;
  localparam int CNT_W   = 27;

  // Period shrinks by step per level but never drops below floor.
  function automatic logic [CNT_W-1:0] drain_period(
    input logic [LEVEL_W-1:0] lvl,
    input int                 base,
    input int                 step,
    input int                 floor
  );
    int p;
    p = base - int'(lvl) * step;
    if (p < floor) p = floor;
    return p[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/game_sequencer_health_drain.sv
// Health register with level-scaled periodic drain.
// Ports: load (game start), active, add/sub_penalty, level -> health, health_next.
module health_drain
  import game_pkg::*;
#(
  parameter int HEALTH_MAX    = 99,
  parameter int HEALTH_W      = 7,
  parameter int HEALTH_GAIN   = 5,
  parameter int WRONG_PENALTY = 10,
  parameter int BASE_TICKS    = 36000000,
  parameter int TICK_STEP     = 3000000,
  parameter int MIN_TICKS     = 12000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                active,
  input  logic                add,
  input  logic                sub_penalty,
  input  logic [LEVEL_W-1:0]  level,
  output logic [HEALTH_W-1:0] health,
  output logic [HEALTH_W-1:0] health_next
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic             drain;
  int               net;

  // >= rather than == so a level-up that shortens the period
  // below the running count fires on the next compare.
  always_comb begin
    period = drain_period(level, BASE_TICKS, TICK_STEP, MIN_TICKS);
    drain  = active && (cnt >= period - CNT_W'(1));
  end

  // Gain, penalty and drain fold into one clamped update.
  always_comb begin
    net = int'(health);
    if (active) begin
      if (add)         net = net + HEALTH_GAIN;
      if (sub_penalty) net = net - WRONG_PENALTY;
      if (drain)       net = net - 1;
    end
    if (net < 0)          net = 0;
    if (net > HEALTH_MAX) net = HEALTH_MAX;
    health_next = HEALTH_W'(net);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      health <= '0;
    end else if (load) begin
      cnt    <= '0;
      health <= HEALTH_W'(HEALTH_MAX);
    end else if (active) begin
      cnt    <= drain ? '0 : cnt + CNT_W'(1);
      health <= health_next;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Modulus-game controller: problem generation, answer entry, scoring.
// Ports: start/keypad/rand in; problem, answer, health, score, level, state out.
module game_sequencer
  import game_pkg::*;
#(
  parameter int HEALTH_MAX    = 99,
  parameter int HEALTH_W      = 7,
  parameter int HEALTH_GAIN   = 5,
  parameter int WRONG_PENALTY = 10,
  parameter int BASE_TICKS    = 36000000,
  parameter int TICK_STEP     = 3000000,
  parameter int MIN_TICKS     = 12000000,
  parameter int STREAK_UP     = 5,
  parameter int MAX_LEVEL     = 6,
  parameter int ANS_DIGITS    = 2,
  parameter int RETRY_MAX     = 15,
  parameter int SCORE_MAX     = 999
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                key_valid,
  input  logic [3:0]          key_digit,
  input  logic                key_enter,
  input  logic                key_clear,
  input  logic [6:0]          rand_a,
  input  logic [3:0]          rand_b,
  output logic [6:0]          dividend,
  output logic [3:0]          divisor,
  output logic [6:0]          answer_val,
  output logic [1:0]          answer_len,
  output logic [HEALTH_W-1:0] health,
  output logic [SCORE_W-1:0]  score,
  output logic [LEVEL_W-1:0]  level,
  output logic [2:0]          state,
  output logic                correct_p,
  output logic                wrong_p,
  output logic                game_over
);

  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam int SW = $clog2(STREAK_UP + 1);

  state_t              cur, nxt;
  logic [RW-1:0]       retry;
  logic [SW-1:0]       streak;
  logic [HEALTH_W-1:0] health_next;
  logic [3:0]          lim_raw, lim;
  logic                accept, fallback;
  logic                digit_ok, correct;
  logic                init_go, active;
  logic [6:0]          rem;
  logic [7:0]          acc;

  assign state = cur;

  always_comb begin
    lim_raw  = {1'b0, level} + 4'd3;
    lim      = (lim_raw > 4'd9) ? 4'd9 : lim_raw;
    accept   = (rand_b >= 4'd2) && (rand_b <= lim)
            && ({3'b000, rand_b} <= rand_a)
            && (rand_a <= 7'd99);
    fallback = (retry == RW'(RETRY_MAX));
    digit_ok = key_valid && (key_digit <= 4'd9)
            && (answer_len < 2'(ANS_DIGITS));
    acc      = {1'b0, answer_val} * 8'd10
             + {4'b0000, key_digit};
    rem      = dividend % {3'b000, divisor};
    correct  = (answer_val == rem);
    init_go  = start && ((cur == IDLE) || (cur == OVER));
    active   = (cur == GEN) || (cur == WAIT)
            || (cur == CHECK);
  end

  health_drain #(
    .HEALTH_MAX   (HEALTH_MAX),
    .HEALTH_W     (HEALTH_W),
    .HEALTH_GAIN  (HEALTH_GAIN),
    .WRONG_PENALTY(WRONG_PENALTY),
    .BASE_TICKS   (BASE_TICKS),
    .TICK_STEP    (TICK_STEP),
    .MIN_TICKS    (MIN_TICKS)
  ) u_drain (
    .clk        (clk),
    .reset      (reset),
    .load       (init_go),
    .active     (active),
    .add        ((cur == CHECK) && correct),
    .sub_penalty((cur == CHECK) && !correct),
    .level      (level),
    .health     (health),
    .health_next(health_next)
  );

  always_ff @(posedge clk) begin
    if (reset) cur <= IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt       = cur;
    correct_p = 1'b0;
    wrong_p   = 1'b0;
    game_over = 1'b0;
    unique case (cur)
      IDLE:  if (start) nxt = INIT;
      INIT:  nxt = GEN;
      GEN: begin
        if (health == '0)            nxt = OVER;
        else if (accept || fallback) nxt = WAIT;
      end
      WAIT: begin
        if (health == '0) nxt = OVER;
        else if (key_enter && answer_len != 2'd0)
          nxt = CHECK;
      end
      CHECK: begin
        correct_p = correct;
        wrong_p   = !correct;
        nxt       = (health_next == '0) ? OVER : GEN;
      end
      OVER: begin
        game_over = 1'b1;
        if (start) nxt = INIT;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dividend   <= '0;
      divisor    <= '0;
      answer_val <= '0;
      answer_len <= '0;
      score      <= '0;
      level      <= '0;
      streak     <= '0;
      retry      <= '0;
    end else if (init_go) begin
      answer_val <= '0;
      answer_len <= '0;
      score      <= '0;
      level      <= '0;
      streak     <= '0;
      retry      <= '0;
    end else begin
      unique case (cur)
        GEN: if (health != '0) begin
          if (accept) begin
            dividend   <= rand_a;
            divisor    <= rand_b;
            answer_val <= '0;
            answer_len <= '0;
            retry      <= '0;
          end else if (fallback) begin
            dividend   <= {1'b0, rand_a[5:0]} + 7'd2;
            divisor    <= 4'd2;
            answer_val <= '0;
            answer_len <= '0;
            retry      <= '0;
          end else begin
            retry <= retry + RW'(1);
          end
        end
        // Enter wins outright; clear beats a digit.
        WAIT: if (health != '0 && !key_enter) begin
          if (key_clear) begin
            answer_val <= '0;
            answer_len <= '0;
          end else if (digit_ok) begin
            answer_val <= 7'(acc);
            answer_len <= answer_len + 2'd1;
          end
        end
        CHECK: begin
          if (correct) begin
            if (score != SCORE_W'(SCORE_MAX))
              score <= score + SCORE_W'(1);
            if (streak + SW'(1) == SW'(STREAK_UP)) begin
              streak <= '0;
              if (level != LEVEL_W'(MAX_LEVEL))
                level <= level + LEVEL_W'(1);
            end else begin
              streak <= streak + SW'(1);
            end
          end else begin
            streak <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer.
// Short drain periods keep the drain intervals observable.
module tb_game_sequencer;
  import game_pkg::*;

  localparam int S_IDLE  = 0;
  localparam int S_INIT  = 1;
  localparam int S_GEN   = 2;
  localparam int S_WAIT  = 3;
  localparam int S_CHECK = 4;
  localparam int S_OVER  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       key_enter = 1'b0;
  logic       key_clear = 1'b0;
  logic [6:0] rand_a = 7'd0;
  logic [3:0] rand_b = 4'd0;
  logic [6:0] dividend;
  logic [3:0] divisor;
  logic [6:0] answer_val;
  logic [1:0] answer_len;
  logic [6:0] health;
  logic [9:0] score;
  logic [2:0] level;
  logic [2:0] state;
  logic       correct_p;
  logic       wrong_p;
  logic       game_over;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  game_sequencer #(
    .BASE_TICKS(3000),
    .TICK_STEP (500),
    .MIN_TICKS (1200)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .key_enter (key_enter),
    .key_clear (key_clear),
    .rand_a    (rand_a),
    .rand_b    (rand_b),
    .dividend  (dividend),
    .divisor   (divisor),
    .answer_val(answer_val),
    .answer_len(answer_len),
    .health    (health),
    .score     (score),
    .level     (level),
    .state     (state),
    .correct_p (correct_p),
    .wrong_p   (wrong_p),
    .game_over (game_over)
  );

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input int d);
    key_valid = 1'b1;
    key_digit = 4'(d);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic enter();
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
  endtask

  task automatic to_wait(output int n);
    n = 0;
    while (state != 3'(S_WAIT) && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_drain(input int bound, output int n);
    logic [6:0] h0;
    h0 = health;
    n  = 0;
    while (health == h0 && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"},  state,      S_IDLE);
    chk({tag, "_health"}, health,     0);
    chk({tag, "_score"},  score,      0);
    chk({tag, "_level"},  level,      0);
    chk({tag, "_div"},    dividend,   0);
    chk({tag, "_dsr"},    divisor,    0);
    chk({tag, "_aval"},   answer_val, 0);
    chk({tag, "_alen"},   answer_len, 0);
    chk({tag, "_cp"},     correct_p,  0);
    chk({tag, "_wp"},     wrong_p,    0);
    chk({tag, "_go"},     game_over,  0);
  endtask

  // Answer the current problem, then let the next one be generated.
  task automatic do_round(input int ans, input bit ok,
                          input int ra, input int rb);
    int n;
    rand_a = 7'(ra);
    rand_b = 4'(rb);
    if (ans >= 10) key(ans / 10);
    key(ans % 10);
    enter();
    if (ok) chk("round_ok", correct_p, 1);
    else    chk("round_bad", wrong_p, 1);
    tick();
    to_wait(n);
    chk("round_wait", state, S_WAIT);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int h;

    chk("period_l1",
        drain_period(3'd1, 36000000, 3000000, 12000000),
        33000000);
    chk("period_l6",
        drain_period(3'd6, 36000000, 3000000, 12000000),
        18000000);

    repeat (2) tick();
    check_zero("rst");
    reset = 1'b0;
    tick();
    chk("idle_hold", state, S_IDLE);

    // Always-rejected inputs force the fallback problem.
    rand_a = 7'd100;
    rand_b = 4'd1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("init_state", state, S_INIT);
    chk("init_health", health, 99);
    to_wait(n);
    chk("gen_cycles", n - 1, 16);
    chk("fb_divisor", divisor, 2);
    chk("fb_dividend", dividend, 38);

    key(9);
    key(9);
    key(7);
    chk("cap_val", answer_val, 99);
    chk("cap_len", answer_len, 2);
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    chk("clr_val", answer_val, 0);
    chk("clr_len", answer_len, 0);
    enter();
    chk("empty_enter", state, S_WAIT);
    key_valid = 1'b1;
    key_digit = 4'd5;
    enter();
    key_valid = 1'b0;
    chk("enter_drop_st", state, S_WAIT);
    chk("enter_drop_len", answer_len, 0);

    key(0);
    rand_a    = 7'd47;
    rand_b    = 4'd3;
    key_valid = 1'b1;
    key_digit = 4'd7;
    enter();
    key_valid = 1'b0;
    chk("enter_win_st", state, S_CHECK);
    chk("enter_win_val", answer_val, 0);
    chk("c0_pulse", correct_p, 1);
    tick();
    chk("c0_state", state, S_GEN);
    chk("c0_score", score, 1);
    chk("c0_health", health, 99);
    chk("c0_pulse_off", correct_p, 0);
    tick();
    chk("p47_div", dividend, 47);
    chk("p47_dsr", divisor, 3);

    do_round(13, 0, 47, 3);
    chk("wrong_health", health, 89);
    do_round(2, 1, 47, 3);
    chk("gain_health", health, 94);
    chk("gain_score", score, 2);
    repeat (3) do_round(2, 1, 47, 3);
    chk("l0_level", level, 0);
    do_round(2, 1, 47, 3);
    chk("l1_level", level, 1);
    chk("l1_score", score, 6);
    chk("l1_health", health, 99);

    wait_drain(4000, n);
    chk("l1_drain_a", health, 98);
    wait_drain(4000, n);
    chk("l1_period", n, 2500);
    chk("l1_drain_b", health, 97);

    // Divisor 5 is above the level-1 limit of 4.
    do_round(2, 1, 50, 5);
    chk("l1_rej_dsr", divisor, 2);
    chk("l1_rej_div", dividend, 52);
    chk("clamp_health", health, 99);
    chk("fb_score", score, 7);
    do_round(0, 1, 47, 4);
    do_round(3, 1, 47, 4);
    do_round(3, 1, 47, 4);
    do_round(3, 1, 47, 5);
    chk("l2_level", level, 2);
    chk("l2_div", dividend, 47);
    chk("l2_dsr", divisor, 5);
    do_round(2, 1, 47, 5);
    chk("p475_score", score, 12);
    do_round(13, 0, 47, 5);
    chk("p475_health", health, 89);
    chk("p475_level", level, 2);

    repeat (20) do_round(2, 1, 47, 5);
    chk("l6_level", level, 6);
    chk("l6_score", score, 32);
    chk("l6_health", health, 99);
    repeat (5) do_round(2, 1, 47, 5);
    chk("lmax_level", level, 6);
    chk("lmax_score", score, 37);

    do_round(2, 1, 50, 10);
    chk("l6_rej_dsr", divisor, 2);
    chk("l6_rej_div", dividend, 52);
    do_round(0, 1, 50, 9);
    chk("l6_acc_dsr", divisor, 9);
    chk("l6_acc_div", dividend, 50);
    chk("l6b_score", score, 39);

    wait_drain(2000, n);
    chk("l6_drain_a", health, 98);
    wait_drain(2000, n);
    chk("l6_period", n, 1200);
    chk("l6_drain_b", health, 97);
    h = 97;
    repeat (4) begin
      wait_drain(1300, n);
      h = h - 1;
      chk("drain_step", health, h);
    end

    repeat (9) do_round(1, 0, 50, 9);
    chk("pre_over_hp", health, 3);
    key(1);
    enter();
    chk("last_wrong", wrong_p, 1);
    tick();
    chk("over_state", state, S_OVER);
    chk("over_health", health, 0);
    chk("over_flag", game_over, 1);

    key(5);
    enter();
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    rand_a = 7'd20;
    rand_b = 4'd3;
    repeat (5) tick();
    chk("frz_state", state, S_OVER);
    chk("frz_score", score, 39);
    chk("frz_health", health, 0);
    chk("frz_level", level, 6);
    chk("frz_div", dividend, 50);
    chk("frz_dsr", divisor, 9);

    rand_a = 7'd47;
    rand_b = 4'd3;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("restart_st", state, S_INIT);
    chk("restart_hp", health, 99);
    chk("restart_sc", score, 0);
    chk("restart_lv", level, 0);
    chk("restart_go", game_over, 0);
    to_wait(n);
    do_round(2, 1, 47, 3);
    chk("g2_score", score, 1);
    reset = 1'b1;
    tick();
    check_zero("rst_wait");

    reset  = 1'b0;
    rand_a = 7'd100;
    rand_b = 4'd1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (2) tick();
    chk("mid_gen", state, S_GEN);
    reset = 1'b1;
    tick();
    chk("rst_gen_st", state, S_IDLE);
    chk("rst_gen_hp", health, 0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
